power_iteration_ctrl: RTL

Sequencer for the iterative eigenvector estimate in the fetal ECG decomposition. It repeatedly drives an external matrix-vector multiplier (start/f handshake) and an external vector normaliser. The result of each iteration feeds the next, until either CYCLES_M iterations complete or the normaliser flags convergence. It owns the iteration vector registers, the iteration counter and a per-handshake watchdog; it performs no floating-point arithmetic itself.

---
 rtl/power_iteration_ctrl_pkg.sv | 7 +
 rtl/power_iteration_ctrl_handshake_watchdog.sv | 37 +++
 rtl/power_iteration_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/power_iteration_ctrl_pkg.sv
// Shared types for the power-iteration sequencer: raw IEEE-754 double words,
// carried as opaque 64-bit containers since this block does no arithmetic.
package power_iteration_ctrl_pkg;

    typedef logic [63:0] double_t;

endpackage

// File: rtl/power_iteration_ctrl_handshake_watchdog.sv
// Cycle counter bounding one start/finish handshake; flags expiry on the
// TIMEOUT-th consecutive enabled cycle without the partner responding.
module power_iteration_ctrl_handshake_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/power_iteration_ctrl.sv
// Sequencer for iterative eigenvector estimation: alternates an external
// mat-vec multiply and normalise until CYCLES_M iterations or convergence.
module power_iteration_ctrl
    import power_iteration_ctrl_pkg::*;
#(
    parameter int SIZE_N   = 8,
    parameter int CYCLES_M = 5,
    parameter int TIMEOUT  = 1024,
    localparam int IW      = $clog2(CYCLES_M + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  double_t [SIZE_N-1:0]     init_vec,
    output logic                     mult_start,
    output double_t [SIZE_N-1:0]     mult_vec,
    input  double_t [SIZE_N-1:0]     mult_result,
    input  logic                     mult_f,
    output logic                     norm_start,
    output double_t [SIZE_N-1:0]     norm_in,
    input  double_t [SIZE_N-1:0]     norm_out,
    input  logic                     norm_conv,
    input  logic                     norm_f,
    output double_t [SIZE_N-1:0]     vector_out,
    output logic [IW-1:0]            iter_count,
    output logic                     busy,
    output logic                     f,
    output logic                     err
);

    typedef double_t [SIZE_N-1:0] dvec_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MSTART = 3'd1;
    localparam logic [2:0] S_MWAIT  = 3'd2;
    localparam logic [2:0] S_NSTART = 3'd3;
    localparam logic [2:0] S_NWAIT  = 3'd4;
    localparam logic [2:0] S_UPDATE = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]    state_q, state_d;
    dvec_t         cur_vec_q, cur_vec_d;
    dvec_t         tmp_vec_q, tmp_vec_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          conv_q, conv_d;
    logic          f_q, f_d;
    logic          err_q, err_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    // The counter only runs while a wait state sees no matching handshake.
    assign wd_clear  = (state_q == S_MSTART) || (state_q == S_NSTART);
    assign wd_enable = ((state_q == S_MWAIT) && !mult_f) ||
                       ((state_q == S_NWAIT) && !norm_f);

    power_iteration_ctrl_handshake_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        cur_vec_d = cur_vec_q;
        tmp_vec_d = tmp_vec_q;
        iter_d    = iter_q;
        conv_d    = conv_q;
        f_d       = f_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    cur_vec_d = init_vec;
                    iter_d    = '0;
                    conv_d    = 1'b0;
                    f_d       = 1'b0;
                    err_d     = 1'b0;
                    state_d   = S_MSTART;
                end
            end
            S_MSTART: state_d = S_MWAIT;
            S_MWAIT: begin
                if (mult_f) begin
                    tmp_vec_d = mult_result;
                    state_d   = S_NSTART;
                end else if (wd_expired) begin
                    f_d     = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_NSTART: state_d = S_NWAIT;
            S_NWAIT: begin
                if (norm_f) begin
                    cur_vec_d = norm_out;
                    iter_d    = iter_q + IW'(1);
                    conv_d    = norm_conv;
                    state_d   = S_UPDATE;
                end else if (wd_expired) begin
                    f_d     = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_UPDATE: begin
                if (conv_q || (iter_q == IW'(CYCLES_M))) begin
                    f_d     = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_MSTART;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_vec_q <= '0;
            tmp_vec_q <= '0;
            iter_q    <= '0;
            conv_q    <= 1'b0;
            f_q       <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_vec_q <= cur_vec_d;
            tmp_vec_q <= tmp_vec_d;
            iter_q    <= iter_d;
            conv_q    <= conv_d;
            f_q       <= f_d;
            err_q     <= err_d;
        end
    end

    assign mult_start = (state_q == S_MSTART);
    assign norm_start = (state_q == S_NSTART);
    assign mult_vec   = cur_vec_q;
    assign norm_in    = tmp_vec_q;
    assign vector_out = cur_vec_q;
    assign iter_count = iter_q;
    assign busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign f          = f_q;
    assign err        = err_q;

endmodule
